calc_sequencer: RTL and testbench

Sequences the calculator datapath. It walks the read address range of the two SRAM macros, splits each 64-bit memory word into two 32-bit operands for the adder, and steers each sum into the lower or upper half of the result buffer. Every two sums, it writes the packed 64-bit word back over the write address range. It sits between the SRAM pair, adder32 and result_buffer, and is started and monitored by a host through a start/done handshake.

---
 rtl/calculator_pkg.sv | 24 ++
 rtl/calc_addr_gen.sv | 82 ++++++++
 rtl/calc_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// -----------------------------------------------------------------------------
// calculator_pkg
// Shared widths and the sequencer state encoding for the calculator datapath.
//   ADDR_W        : SRAM word address width (512 entries)
//   DATA_W        : adder operand / sum width
//   MEM_WORD_SIZE : SRAM word width, two operands packed side by side
// -----------------------------------------------------------------------------
package calculator_pkg;

    localparam int ADDR_W        = 9;
    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 2 * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ADD   = 3'd3,
        ST_ACC   = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/calc_addr_gen.sv
// -----------------------------------------------------------------------------
// calc_addr_gen
// Read and write pointer counters for the calculator sequencer.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   load_i               : load pointers with the start addresses, latch ends
//   r_start_i, r_end_i   : inclusive read range
//   w_start_i, w_end_i   : inclusive write range
//   r_inc_i, w_inc_i     : advance read / write pointer (modulo 2^ADDR_W)
//   r_ptr_o, w_ptr_o     : current pointers
//   r_last_o             : read pointer sits on the latched read end
//   w_ovf_o              : write pointer has run past the latched write end
// -----------------------------------------------------------------------------
module calc_addr_gen
    import calculator_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] r_start_i,
    input  logic [ADDR_W-1:0] r_end_i,
    input  logic [ADDR_W-1:0] w_start_i,
    input  logic [ADDR_W-1:0] w_end_i,
    input  logic              r_inc_i,
    input  logic              w_inc_i,
    output logic [ADDR_W-1:0] r_ptr_o,
    output logic [ADDR_W-1:0] w_ptr_o,
    output logic              r_last_o,
    output logic              w_ovf_o
);

    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W-1:0] r_end_q, r_end_d;
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] w_end_q, w_end_d;

    // Next pointer values: load wins over increment.
    always_comb begin
        r_ptr_d = r_ptr_q;
        r_end_d = r_end_q;
        w_ptr_d = w_ptr_q;
        w_end_d = w_end_q;
        if (load_i) begin
            r_ptr_d = r_start_i;
            r_end_d = r_end_i;
            w_ptr_d = w_start_i;
            w_end_d = w_end_i;
        end else begin
            if (r_inc_i) begin
                r_ptr_d = r_ptr_q + ADDR_W'(1);
            end else begin
                r_ptr_d = r_ptr_q;
            end
            if (w_inc_i) begin
                w_ptr_d = w_ptr_q + ADDR_W'(1);
            end else begin
                w_ptr_d = w_ptr_q;
            end
        end
    end

    // Pointer and range registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr_q <= '0;
            r_end_q <= '0;
            w_ptr_q <= '0;
            w_end_q <= '0;
        end else begin
            r_ptr_q <= r_ptr_d;
            r_end_q <= r_end_d;
            w_ptr_q <= w_ptr_d;
            w_end_q <= w_end_d;
        end
    end

    assign r_ptr_o  = r_ptr_q;
    assign w_ptr_o  = w_ptr_q;
    // Equality, not magnitude: a read end of 511 must stop before the wrap.
    assign r_last_o = (r_ptr_q == r_end_q);
    assign w_ovf_o  = (w_ptr_q > w_end_q);

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Walks the SRAM read range, feeds each 64-bit word to adder32 as two 32-bit
// operands, steers sums into alternating halves of the result buffer and
// writes each packed pair back over the write range.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   start_i                     : run request (only sampled when idle)
//   read_/write_start/end_addr  : inclusive address ranges
//   read_o, r_addr_o, r_data_i  : SRAM read port
//   op_a_o, op_b_o              : registered adder operands
//   buf_we_o, buffer_control_o  : latch sum into buffer half (1 = upper)
//   buf_clr_o, buff_result_i    : buffer clear / packed buffer contents
//   write_o, w_addr_o, w_data_o : SRAM write port
//   busy_o, done_o, err_o       : host status
// -----------------------------------------------------------------------------
module calc_sequencer
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        read_start_addr,
    input  logic [ADDR_W-1:0]        read_end_addr,
    input  logic [ADDR_W-1:0]        write_start_addr,
    input  logic [ADDR_W-1:0]        write_end_addr,
    output logic                     read_o,
    output logic [ADDR_W-1:0]        r_addr_o,
    input  logic [MEM_WORD_SIZE-1:0] r_data_i,
    output logic [DATA_W-1:0]        op_a_o,
    output logic [DATA_W-1:0]        op_b_o,
    output logic                     buf_we_o,
    output logic                     buffer_control_o,
    output logic                     buf_clr_o,
    input  logic [MEM_WORD_SIZE-1:0] buff_result_i,
    output logic                     write_o,
    output logic [ADDR_W-1:0]        w_addr_o,
    output logic [MEM_WORD_SIZE-1:0] w_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    seq_state_e        state_q, state_d;
    logic              half_q, half_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;

    logic              load_s, r_inc_s, w_inc_s, range_bad_s;
    logic [ADDR_W-1:0] r_ptr_s, w_ptr_s;
    logic              r_last_s, w_ovf_s;

    assign range_bad_s = (read_end_addr < read_start_addr);

    calc_addr_gen u_addr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load_s),
        .r_start_i (read_start_addr),
        .r_end_i   (read_end_addr),
        .w_start_i (write_start_addr),
        .w_end_i   (write_end_addr),
        .r_inc_i   (r_inc_s),
        .w_inc_i   (w_inc_s),
        .r_ptr_o   (r_ptr_s),
        .w_ptr_o   (w_ptr_s),
        .r_last_o  (r_last_s),
        .w_ovf_o   (w_ovf_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            half_q  <= 1'b0;
            err_q   <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            err_q   <= err_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = range_bad_s ? ST_DONE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_ADD;
            ST_ADD:   state_d = ST_ACC;
            ST_ACC: begin
                if (half_q || r_last_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (w_ovf_s || r_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pointer strobes, half select, sticky error and operand capture.
    always_comb begin
        load_s  = (state_q == ST_IDLE) && start_i;
        r_inc_s = 1'b0;
        w_inc_s = 1'b0;
        half_d  = half_q;
        err_d   = err_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    half_d = 1'b0;
                    err_d  = range_bad_s;
                end else begin
                    half_d = half_q;
                end
            end
            ST_ADD: begin
                op_a_d = r_data_i[MEM_WORD_SIZE-1:DATA_W];
                op_b_d = r_data_i[DATA_W-1:0];
            end
            ST_ACC: begin
                // First half of a pair and more data to come: fetch the next word.
                if (!half_q && !r_last_s) begin
                    half_d  = 1'b1;
                    r_inc_s = 1'b1;
                end else begin
                    half_d  = half_q;
                end
            end
            ST_WRITE: begin
                if (w_ovf_s) begin
                    err_d = 1'b1;
                end else begin
                    w_inc_s = 1'b1;
                    half_d  = 1'b0;
                    r_inc_s = !r_last_s;
                end
            end
            default: begin
                half_d = half_q;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        read_o           = 1'b0;
        r_addr_o         = '0;
        buf_we_o         = 1'b0;
        buffer_control_o = 1'b0;
        buf_clr_o        = 1'b0;
        write_o          = 1'b0;
        w_addr_o         = '0;
        w_data_o         = '0;
        done_o           = 1'b0;
        busy_o           = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: buf_clr_o = start_i;
            ST_READ: begin
                read_o   = 1'b1;
                r_addr_o = r_ptr_s;
            end
            ST_ACC: begin
                buf_we_o         = 1'b1;
                buffer_control_o = half_q;
            end
            ST_WRITE: begin
                // The clear lands on the same edge the SRAM captures the data.
                if (!w_ovf_s) begin
                    write_o   = 1'b1;
                    w_addr_o  = w_ptr_s;
                    w_data_o  = buff_result_i;
                    buf_clr_o = 1'b1;
                end else begin
                    write_o   = 1'b0;
                end
            end
            ST_DONE: done_o = 1'b1;
            default: done_o = 1'b0;
        endcase
    end

    assign op_a_o = op_a_q;
    assign op_b_o = op_b_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
// Bench around calc_sequencer with an SRAM, 32-bit adder and result buffer
// modelled behaviourally. A run model derives the expected read addresses,
// write transactions, DONE cycle and error flag from the range arguments.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic [8:0]  read_start_addr, read_end_addr, write_start_addr, write_end_addr;
    logic        read_o, buf_we_o, buffer_control_o, buf_clr_o, write_o;
    logic        busy_o, done_o, err_o;
    logic [8:0]  r_addr_o, w_addr_o;
    logic [31:0] op_a_o, op_b_o, sum;
    logic [63:0] w_data_o, rdata, buff;

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .read_start_addr  (read_start_addr),
        .read_end_addr    (read_end_addr),
        .write_start_addr (write_start_addr),
        .write_end_addr   (write_end_addr),
        .read_o           (read_o),
        .r_addr_o         (r_addr_o),
        .r_data_i         (rdata),
        .op_a_o           (op_a_o),
        .op_b_o           (op_b_o),
        .buf_we_o         (buf_we_o),
        .buffer_control_o (buffer_control_o),
        .buf_clr_o        (buf_clr_o),
        .buff_result_i    (buff),
        .write_o          (write_o),
        .w_addr_o         (w_addr_o),
        .w_data_o         (w_data_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    // Environment: SRAM with one-cycle read latency, truncating adder, buffer.
    logic [63:0] mem [0:511];
    always @(posedge clk) if (read_o) rdata <= mem[r_addr_o];
    assign sum = op_a_o + op_b_o;
    always @(posedge clk) begin
        if (rst_i || buf_clr_o) buff <= 64'd0;
        else if (buf_we_o) begin
            if (buffer_control_o) buff[63:32] <= sum;
            else                  buff[31:0]  <= sum;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected behaviour of one run.
    logic [8:0]  exp_reads[$];
    logic [8:0]  exp_waddr[$];
    logic [63:0] exp_wdata[$];
    int          exp_cycles;
    logic        exp_err;

    function automatic logic [31:0] add32(input logic [63:0] w);
        return w[63:32] + w[31:0];
    endfunction

    task automatic build_model(input int rs, input int re, input int ws, input int we);
        int n, wa, cyc;
        logic [31:0] lo, hi;
        exp_reads.delete(); exp_waddr.delete(); exp_wdata.delete();
        exp_err = 1'b0;
        cyc = 0;
        if (re < rs) begin
            exp_err = 1'b1;
        end else begin
            n = re - rs + 1;
            for (int k = 0; k < n; k += 2) begin
                exp_reads.push_back(9'(rs + k));
                lo = add32(mem[rs + k]);
                hi = 32'd0;
                cyc += 5;
                if (k + 1 < n) begin
                    exp_reads.push_back(9'(rs + k + 1));
                    hi = add32(mem[rs + k + 1]);
                    cyc += 4;
                end
                wa = ws + k / 2;
                if (wa > we) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_waddr.push_back(9'(wa));
                exp_wdata.push_back({hi, lo});
            end
        end
        exp_cycles = cyc;
    endtask

    // Compare process: checks strobes, addresses, data and completion each cycle.
    bit          done_seen;
    logic        prev_done = 1'b0;
    int          bidx = 0;
    int          nwrites, nreads;
    logic [8:0]  last_waddr;
    logic [63:0] last_wdata;

    always @(negedge clk) begin
        if (!rst_i) begin
            chk("rd_wr_exclusive", 64'(read_o & write_o), 64'd0);
            if (prev_done) chk("done_one_cycle", 64'({done_o, busy_o}), 64'd0);
            if (read_o) begin
                nreads++;
                if (exp_reads.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_read: addr %0d, none required", r_addr_o);
                end else chk("read_addr", 64'(r_addr_o), 64'(exp_reads.pop_front()));
            end
            if (write_o) begin
                nwrites++;
                last_waddr = w_addr_o;
                last_wdata = w_data_o;
                if (exp_waddr.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %h, none required", w_addr_o, w_data_o);
                end else begin
                    chk("write_addr", 64'(w_addr_o), 64'(exp_waddr.pop_front()));
                    chk("write_data", w_data_o, exp_wdata.pop_front());
                end
            end
            if (done_o) begin
                done_seen = 1'b1;
                chk("done_cycle", 64'(bidx), 64'(exp_cycles));
                chk("err_at_done", 64'(err_o), 64'(exp_err));
                chk("reads_left", 64'(exp_reads.size()), 64'd0);
                chk("writes_left", 64'(exp_waddr.size()), 64'd0);
            end
            prev_done = done_o;
            bidx = busy_o ? bidx + 1 : 0;
        end else begin
            prev_done = 1'b0;
            bidx = 0;
        end
    end

    task automatic check_zero(input string p);
        chk({p, "_ctrl"}, 64'({read_o, buf_we_o, buffer_control_o, buf_clr_o,
                              write_o, busy_o, done_o, err_o}), 64'd0);
        chk({p, "_addr"}, 64'({r_addr_o, w_addr_o}), 64'd0);
        chk({p, "_ops"}, {op_a_o, op_b_o}, 64'd0);
        chk({p, "_wdata"}, w_data_o, 64'd0);
    endtask

    task automatic run(input int rs, input int re, input int ws, input int we, input bit extra);
        build_model(rs, re, ws, we);
        nwrites = 0; nreads = 0; done_seen = 1'b0;
        @(posedge clk); #1;
        read_start_addr  = 9'(rs);
        read_end_addr    = 9'(re);
        write_start_addr = 9'(ws);
        write_end_addr   = 9'(we);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (extra) begin
            // Now in READ: a second start and a changed range must be ignored.
            start_i = 1'b1;
            read_end_addr = 9'd5;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        for (int t = 0; t < 300 && !done_seen; t++) @(posedge clk);
        chk("done_seen", 64'(done_seen), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0;
        read_start_addr = 9'd0; read_end_addr = 9'd0;
        write_start_addr = 9'd0; write_end_addr = 9'd0;
        for (int i = 0; i < 512; i++) mem[i] = {32'(i * 3 + 100), 32'hF000_0000 + 32'(i)};
        mem[0] = {32'd5, 32'd7};
        mem[1] = {32'hFFFF_FFFF, 32'd2};

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Two reads, one write; second sum wraps to 1.
        run(0, 1, 10, 10, 1'b0);
        chk("two_model_cycles", 64'(exp_cycles), 64'd9);
        chk("two_nwrites", 64'(nwrites), 64'd1);
        chk("two_waddr", 64'(last_waddr), 64'd10);
        chk("two_wdata", last_wdata, {32'd1, 32'd12});
        chk("two_err", 64'(err_o), 64'd0);

        // Odd read count: last write carries a zero upper half.
        run(4, 6, 20, 21, 1'b0);
        chk("odd_model_cycles", 64'(exp_cycles), 64'd14);
        chk("odd_nwrites", 64'(nwrites), 64'd2);
        chk("odd_waddr", 64'(last_waddr), 64'd21);
        chk("odd_upper_zero", 64'(last_wdata[63:32]), 64'd0);
        chk("odd_lower", 64'(last_wdata[31:0]), 64'(32'd118 + 32'hF000_0006));

        // Write range overflow on the second pair.
        run(0, 3, 8, 8, 1'b0);
        chk("ovf_model_cycles", 64'(exp_cycles), 64'd18);
        chk("ovf_nwrites", 64'(nwrites), 64'd1);
        chk("ovf_waddr", 64'(last_waddr), 64'd8);
        chk("ovf_err_sticky", 64'(err_o), 64'd1);

        // Reset during WAIT of the second read aborts the run.
        exp_reads.delete(); exp_waddr.delete(); exp_wdata.delete();
        exp_reads.push_back(9'd0);
        exp_reads.push_back(9'd1);
        nwrites = 0; nreads = 0;
        @(posedge clk); #1;
        read_start_addr = 9'd0; read_end_addr = 9'd3;
        write_start_addr = 9'd30; write_end_addr = 9'd31;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_reads", 64'(nreads), 64'd2);
        chk("midrst_reads_left", 64'(exp_reads.size()), 64'd0);
        chk("midrst_nwrites", 64'(nwrites), 64'd0);

        // Invalid read range: straight to DONE with error.
        run(5, 3, 0, 0, 1'b0);
        chk("inv_nreads", 64'(nreads), 64'd0);
        chk("inv_nwrites", 64'(nwrites), 64'd0);
        chk("inv_err_sticky", 64'(err_o), 64'd1);

        // Start pulse while busy is ignored; result identical to plain run.
        run(0, 1, 12, 12, 1'b1);
        chk("busy_nwrites", 64'(nwrites), 64'd1);
        chk("busy_waddr", 64'(last_waddr), 64'd12);
        chk("busy_wdata", last_wdata, {32'd1, 32'd12});
        chk("busy_err", 64'(err_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
